light_timer_ctrl: RTL and testbench

Controller that sequences the room light from two sources: the manual on/off push switch and a motion sensor. It debounces the switch and turns presses into toggles. Motion gives a timed auto-on period that ends with a blinking warning phase before switch-off. It drives the light enable directly and exposes its state for status LEDs and the bench.

---
 rtl/light_pkg.sv | 18 +
 rtl/sw_debounce.sv | 56 +++++
 rtl/light_timer_ctrl.sv | 118 +++++++++++
 tb/tb_light_timer_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the room light controller: state encodings and
// default timing constants.
package light_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2,
    ST_WARN   = 2'd3
  } state_e;

  localparam int DB_CYC_DEF   = 4;
  localparam int DB_W_DEF     = 3;
  localparam int HOLD_CYC_DEF = 20;
  localparam int WARN_CYC_DEF = 5;
  localparam int TMR_W_DEF    = 5;

endpackage

// File: rtl/sw_debounce.sv
// Push-switch conditioning: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module sw_debounce
  import light_pkg::*;
#(
  parameter int DB_CYC = DB_CYC_DEF,
  parameter int DB_W   = DB_W_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_level,
  output logic o_press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      // Accept the new level once it has differed for DB_CYC consecutive edges.
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= i_sw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign o_level = level_q;
  assign o_press = level_q & ~level_dly_q;

endmodule

// File: rtl/light_timer_ctrl.sv
// Room light sequencer: manual toggle from the debounced switch, motion-driven
// timed auto-on with a blinking warning phase before switch-off.
module light_timer_ctrl
  import light_pkg::*;
#(
  parameter int DB_CYC   = DB_CYC_DEF,
  parameter int DB_W     = DB_W_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int WARN_CYC = WARN_CYC_DEF,
  parameter int TMR_W    = TMR_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_OnOffSW,
  input  logic       i_motion,
  output logic       o_light,
  output logic [1:0] o_state,
  output logic       o_warn
);

  localparam logic [TMR_W-1:0] HOLD_V = TMR_W'(HOLD_CYC);
  localparam logic [TMR_W-1:0] WARN_V = TMR_W'(WARN_CYC);

  logic             press;
  logic             sw_level_unused;
  logic             mot_s1_q, mot_s2_q;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] tmr_dec;

  sw_debounce #(
    .DB_CYC (DB_CYC),
    .DB_W   (DB_W)
  ) u_sw_debounce (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sw    (i_OnOffSW),
    .o_level (sw_level_unused),
    .o_press (press)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mot_s1_q <= 1'b0;
      mot_s2_q <= 1'b0;
      state_q  <= ST_OFF;
      timer_q  <= '0;
    end else begin
      mot_s1_q <= i_motion;
      mot_s2_q <= mot_s1_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
    end
  end

  assign tmr_dec = timer_q - 1'b1;

  // Press has priority over motion in every state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_OFF: begin
        if (press) begin
          state_d = ST_MANUAL;
        end else if (mot_s2_q) begin
          state_d = ST_AUTO;
          timer_d = HOLD_V;
        end
      end
      ST_MANUAL: begin
        timer_d = '0;
        if (press) state_d = ST_OFF;
      end
      ST_AUTO: begin
        if (press) begin
          state_d = ST_MANUAL;
          timer_d = '0;
        end else if (mot_s2_q) begin
          timer_d = HOLD_V;
        end else begin
          timer_d = tmr_dec;
          if (tmr_dec <= WARN_V) state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        if (press) begin
          state_d = ST_MANUAL;
          timer_d = '0;
        end else if (mot_s2_q) begin
          state_d = ST_AUTO;
          timer_d = HOLD_V;
        end else begin
          timer_d = tmr_dec;
          if (tmr_dec == '0) state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        timer_d = '0;
      end
    endcase
  end

  // Warning blink follows the timer LSB so it toggles every cycle.
  always_comb begin
    o_light = 1'b0;
    unique case (state_q)
      ST_MANUAL, ST_AUTO: o_light = 1'b1;
      ST_WARN:            o_light = timer_q[0];
      default:            o_light = 1'b0;
    endcase
  end

  assign o_state = state_q;
  assign o_warn  = (state_q == ST_WARN);

endmodule

// File: tb/tb_light_timer_ctrl.sv
// Scoreboard bench for light_timer_ctrl: stimulus queues cycle-tagged expected
// outputs, a monitor compares them on the falling edge.
module tb_light_timer_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_OnOffSW;
  logic       i_motion;
  logic       o_light;
  logic [1:0] o_state;
  logic       o_warn;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       light;
    logic       warn;
    string      name;
  } exp_t;

  exp_t q[$];

  light_timer_ctrl dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_OnOffSW (i_OnOffSW),
    .i_motion  (i_motion),
    .o_light   (o_light),
    .o_state   (o_state),
    .o_warn    (o_warn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [1:0] st, input logic lt,
                           input logic wn, input string nm);
    exp_t e;
    e.cyc = c; e.st = st; e.light = lt; e.warn = wn; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation tagged with the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || {o_state, o_light, o_warn} !== {e.st, e.light, e.warn}) begin
          errors++;
          $display("FAIL %s cyc=%0d (want cyc %0d): got state=%0d light=%0b warn=%0b, expected state=%0d light=%0b warn=%0b",
                   e.name, cyc, e.cyc, o_state, o_light, o_warn, e.st, e.light, e.warn);
        end
      end
    end
  end

  initial begin
    int c;
    i_reset   = 1'b0;
    i_OnOffSW = 1'b0;
    i_motion  = 1'b0;
    expect_at(2, 2'd0, 1'b0, 1'b0, "reset_state");
    expect_at(8, 2'd0, 1'b0, 1'b0, "reset_hold");
    #100;
    step(1);
    i_reset = 1'b1;
    step(3);

    // 1: debounced press toggles MANUAL on, release ignored, second press off
    c = cyc;
    i_OnOffSW = 1'b1;
    expect_at(c + 6, 2'd0, 1'b0, 1'b0, "t1_before_latency");
    expect_at(c + 7, 2'd1, 1'b1, 1'b0, "t1_manual_on");
    step(8);
    i_OnOffSW = 1'b0;
    c = cyc;
    expect_at(c + 10, 2'd1, 1'b1, 1'b0, "t1_release_stays");
    step(12);
    c = cyc;
    i_OnOffSW = 1'b1;
    expect_at(c + 6, 2'd1, 1'b1, 1'b0, "t1_press2_pending");
    expect_at(c + 7, 2'd0, 1'b0, 1'b0, "t1_manual_off");
    step(8);
    i_OnOffSW = 1'b0;
    step(10);

    // 2: short bounces 3/1/2 cycles are rejected
    c = cyc;
    for (int i = 1; i <= 14; i++) expect_at(c + i, 2'd0, 1'b0, 1'b0, "t2_bounce_rejected");
    i_OnOffSW = 1'b1; step(3);
    i_OnOffSW = 1'b0; step(1);
    i_OnOffSW = 1'b1; step(2);
    i_OnOffSW = 1'b0; step(10);

    // 3: motion pulse -> 15 AUTO, 5 WARN blinking, then OFF
    c = cyc;
    expect_at(c + 2, 2'd0, 1'b0, 1'b0, "t3_motion_latency");
    for (int i = 0; i < 15; i++) expect_at(c + 3 + i, 2'd2, 1'b1, 1'b0, "t3_auto");
    for (int i = 0; i < 5; i++)
      expect_at(c + 18 + i, 2'd3, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, "t3_warn_blink");
    expect_at(c + 23, 2'd0, 1'b0, 1'b0, "t3_off");
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(26);

    // 4: motion during WARN (timer 3) reloads AUTO
    c = cyc;
    expect_at(c + 3, 2'd2, 1'b1, 1'b0, "t4_auto");
    expect_at(c + 20, 2'd3, 1'b1, 1'b1, "t4_warn_t3");
    expect_at(c + 21, 2'd2, 1'b1, 1'b0, "t4_rearm_auto");
    expect_at(c + 35, 2'd2, 1'b1, 1'b0, "t4_reload_auto_end");
    expect_at(c + 36, 2'd3, 1'b1, 1'b1, "t4_reload_warn");
    expect_at(c + 41, 2'd0, 1'b0, 1'b0, "t4_off");
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(17);
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(25);

    // 5: press and motion on the same edge in AUTO -> MANUAL, motion ignored
    c = cyc;
    expect_at(c + 11, 2'd2, 1'b1, 1'b0, "t5_auto");
    expect_at(c + 12, 2'd1, 1'b1, 1'b0, "t5_press_wins");
    expect_at(c + 17, 2'd1, 1'b1, 1'b0, "t5_motion_ignored");
    expect_at(c + 18, 2'd1, 1'b1, 1'b0, "t5_motion_ignored2");
    expect_at(c + 36, 2'd1, 1'b1, 1'b0, "t5_press2_pending");
    expect_at(c + 37, 2'd0, 1'b0, 1'b0, "t5_off");
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(4);
    i_OnOffSW = 1'b1; step(4);
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(4);
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(5);
    i_OnOffSW = 1'b0; step(10);
    i_OnOffSW = 1'b1; step(8);
    i_OnOffSW = 1'b0; step(10);

    // 6: asynchronous reset in WARN clears outputs without a clock edge
    c = cyc;
    expect_at(c + 18, 2'd3, 1'b1, 1'b1, "t6_warn");
    i_motion = 1'b1; step(1);
    i_motion = 1'b0; step(18);
    #1;
    i_reset = 1'b0;
    expect_at(c + 19, 2'd0, 1'b0, 1'b0, "t6_async_reset");
    step(3);
    i_reset = 1'b1;
    for (int i = 1; i <= 10; i++) expect_at(c + 22 + i, 2'd0, 1'b0, 1'b0, "t6_after_release");
    step(12);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
